// File: rtl/mc_pkg.sv
// Shared types for the multicycle datapath: opcodes,
// controller states and instruction field layout helpers.
package mc_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 3'd0,
        OP_LI   = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_LW   = 3'd4,
        OP_SW   = 3'd5,
        OP_BEQZ = 3'd6,
        OP_HALT = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Field LSB positions: {opcode, rd, rs, imm}
    function automatic int rs_lsb(input int raw, input int immw);
        return immw;
    endfunction

    function automatic int rd_lsb(input int raw, input int immw);
        return immw + raw;
    endfunction

    function automatic int opc_lsb(input int raw, input int immw);
        return immw + 2 * raw;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// NREG x DW register file: one write port, two operand read
// ports and one probe read port; async active-low clear.
// Ports: clk, rst_n, we/waddr/wdata, ra_*, rb_*, rp_* (probe).
module mc_regfile
    import mc_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 8,
    parameter int RAW  = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [RAW-1:0] waddr,
    input  logic [DW-1:0]  wdata,
    input  logic [RAW-1:0] ra_addr,
    output logic [DW-1:0]  ra_data,
    input  logic [RAW-1:0] rb_addr,
    output logic [DW-1:0]  rb_data,
    input  logic [RAW-1:0] rp_addr,
    output logic [DW-1:0]  rp_data
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];
    assign rp_data = regs_q[rp_addr];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath: PC, register file, data memory and FSM.
// Ports: clk, rst (async active-low), run, instr_addr/instr (sync
// ROM), pc, halted, reg_we, mem_we, register and memory probes.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int DW     = 32,
    parameter int NREG   = 8,
    parameter int MDEPTH = 16,
    parameter int PCW    = 8,
    parameter int IMMW   = 8,
    parameter int RAW    = $clog2(NREG),
    parameter int MAW    = $clog2(MDEPTH),
    parameter int IW     = OPC_W + 2 * RAW + IMMW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    output logic [PCW-1:0] instr_addr,
    input  logic [IW-1:0]  instr,
    output logic [PCW-1:0] pc,
    output logic           halted,
    output logic           reg_we,
    output logic           mem_we,
    input  logic [RAW-1:0] probe_reg_addr,
    output logic [DW-1:0]  probe_register_file,
    input  logic [MAW-1:0] probe_mem_addr,
    output logic [DW-1:0]  probe_data_memory
);

    localparam int RS_LSB  = rs_lsb(RAW, IMMW);
    localparam int RD_LSB  = rd_lsb(RAW, IMMW);
    localparam int OPC_LSB = opc_lsb(RAW, IMMW);

    state_e         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [IW-1:0]  ir_q, ir_d;
    logic [DW-1:0]  op_a_q, op_a_d;
    logic [DW-1:0]  op_b_q, op_b_d;
    logic [DW-1:0]  res_q, res_d;
    logic [MAW-1:0] addr_q, addr_d;
    logic           reg_we_q, reg_we_d;
    logic           mem_we_q, mem_we_d;
    logic           halted_q, halted_d;

    logic [DW-1:0]  mem_q [MDEPTH];
    logic [DW-1:0]  mem_d [MDEPTH];

    opcode_e        opc;
    logic [RAW-1:0] ir_rd;
    logic [RAW-1:0] in_rd, in_rs;
    logic [IMMW-1:0] imm;
    logic [DW-1:0]  simm_dw;
    logic [PCW-1:0] simm_pc;
    logic [PCW-1:0] pc_inc;
    logic [MAW-1:0] ea;
    logic [DW-1:0]  rd_val, rs_val;

    assign opc     = opcode_e'(ir_q[OPC_LSB +: OPC_W]);
    assign ir_rd   = ir_q[RD_LSB +: RAW];
    assign imm     = ir_q[IMMW-1:0];
    assign in_rd   = instr[RD_LSB +: RAW];
    assign in_rs   = instr[RS_LSB +: RAW];
    assign simm_dw = DW'($signed(imm));
    assign simm_pc = PCW'($signed(imm));
    assign pc_inc  = pc_q + PCW'(1);
    // Effective address keeps only the low MAW bits (mod MDEPTH)
    assign ea      = MAW'(op_b_q + simm_dw);

    mc_regfile #(
        .DW   (DW),
        .NREG (NREG),
        .RAW  (RAW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst),
        .we      (reg_we_q),
        .waddr   (ir_rd),
        .wdata   (res_q),
        .ra_addr (in_rd),
        .ra_data (rd_val),
        .rb_addr (in_rs),
        .rb_data (rs_val),
        .rp_addr (probe_reg_addr),
        .rp_data (probe_register_file)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        res_d    = res_q;
        addr_d   = addr_q;
        reg_we_d = 1'b0;
        mem_we_d = 1'b0;
        halted_d = halted_q;
        unique case (state_q)
            ST_FETCH: begin
                if (run) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // Operands captured here, so rd == rs sees old value
                ir_d    = instr;
                op_a_d  = rd_val;
                op_b_d  = rs_val;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                unique case (opc)
                    OP_NOP: begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                    OP_BEQZ: begin
                        pc_d    = (op_a_q == '0) ? pc_q + simm_pc
                                                 : pc_inc;
                        state_d = ST_FETCH;
                    end
                    OP_LI, OP_ADD, OP_SUB: begin
                        res_d    = (opc == OP_LI)  ? simm_dw :
                                   (opc == OP_ADD) ? op_a_q + op_b_q :
                                                     op_a_q - op_b_q;
                        reg_we_d = 1'b1;
                        state_d  = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        addr_d   = ea;
                        mem_we_d = (opc == OP_SW);
                        state_d  = ST_MEM;
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (opc == OP_SW) begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end else begin
                    res_d    = mem_q[addr_q];
                    reg_we_d = 1'b1;
                    state_d  = ST_WB;
                end
            end
            ST_WB: begin
                pc_d    = pc_inc;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            addr_q   <= '0;
            reg_we_q <= 1'b0;
            mem_we_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            addr_q   <= addr_d;
            reg_we_q <= reg_we_d;
            mem_we_q <= mem_we_d;
            halted_q <= halted_d;
        end
    end

    // SW stores the rd operand at the address computed in EXEC
    always_comb begin
        mem_d = mem_q;
        if (mem_we_q) mem_d[addr_q] = op_a_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MDEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign instr_addr        = pc_q;
    assign pc                = pc_q;
    assign halted            = halted_q;
    assign reg_we            = reg_we_q;
    assign mem_we            = mem_we_q;
    assign probe_data_memory = mem_q[probe_mem_addr];

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: single-stepped instruction
// table with scoreboard plus reset, HALT and run corner sequences.
module tb_mc_datapath;

    localparam int IW = 17;

    logic          clk;
    logic          rst;
    logic          run;
    logic [7:0]    instr_addr;
    logic [IW-1:0] instr;
    logic [7:0]    pc;
    logic          halted;
    logic          reg_we;
    logic          mem_we;
    logic [2:0]    probe_reg_addr;
    logic [31:0]   probe_register_file;
    logic [3:0]    probe_mem_addr;
    logic [31:0]   probe_data_memory;

    logic [IW-1:0] rom [256];

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]    at;
        logic [IW-1:0] ins;
        logic [7:0]    epc;
        int            ecyc;
        logic [2:0]    creg;
        logic [31:0]   ereg;
        logic [3:0]    cmem;
        logic [31:0]   emem;
        int            erw;
        int            emw;
    } vec_t;

    vec_t vecs [20];
    vec_t exp_q [$];

    mc_datapath dut (
        .clk                 (clk),
        .rst                 (rst),
        .run                 (run),
        .instr_addr          (instr_addr),
        .instr               (instr),
        .pc                  (pc),
        .halted              (halted),
        .reg_we              (reg_we),
        .mem_we              (mem_we),
        .probe_reg_addr      (probe_reg_addr),
        .probe_register_file (probe_register_file),
        .probe_mem_addr      (probe_mem_addr),
        .probe_data_memory   (probe_data_memory)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) instr <= rom[instr_addr];

    function automatic logic [IW-1:0] enc(input int op, input int rd,
                                          input int rs, input int imm);
        logic [2:0] o;
        logic [2:0] d;
        logic [2:0] s;
        logic [7:0] i;
        o = 3'(op);
        d = 3'(rd);
        s = 3'(rs);
        i = 8'(imm);
        return {o, d, s, i};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one instruction: run high for one FETCH, then wait
    // until the PC moves, counting cycles and strobes.
    task automatic step(input vec_t v);
        vec_t e;
        int cyc;
        int rw;
        int mw;
        logic [7:0] pc0;
        chk("pre_pc", 32'(pc), 32'(v.at));
        exp_q.push_back(v);
        pc0 = pc;
        rw  = 0;
        mw  = 0;
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        cyc = 1;
        while (pc == pc0 && cyc < 12) begin
            @(negedge clk);
            rw += int'(reg_we);
            mw += int'(mem_we);
            @(posedge clk);
            #1;
            cyc++;
        end
        @(negedge clk);
        e = exp_q.pop_front();
        probe_reg_addr = e.creg;
        probe_mem_addr = e.cmem;
        #1;
        chk("step_pc", 32'(pc), 32'(e.epc));
        chk("step_cycles", 32'(cyc), 32'(e.ecyc));
        chk("step_reg", probe_register_file, e.ereg);
        chk("step_mem", probe_data_memory, e.emem);
        chk("step_reg_we", 32'(rw), 32'(e.erw));
        chk("step_mem_we", 32'(mw), 32'(e.emw));
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b0;
        probe_reg_addr = '0;
        probe_mem_addr = '0;
        for (int i = 0; i < 256; i++) rom[i] = '0;

        //          at     instr                 pc    cyc r  rval           m  mval          rw mw
        vecs[0]  = '{8'd0,   enc(1,1,0,5),        8'd1,   4, 1, 32'd5,        3, 32'd0,        1, 0};
        vecs[1]  = '{8'd1,   enc(1,2,0,7),        8'd2,   4, 2, 32'd7,        3, 32'd0,        1, 0};
        vecs[2]  = '{8'd2,   enc(2,1,2,0),        8'd3,   4, 1, 32'd12,       3, 32'd0,        1, 0};
        vecs[3]  = '{8'd3,   enc(5,1,0,3),        8'd4,   4, 1, 32'd12,       3, 32'd12,       0, 1};
        vecs[4]  = '{8'd4,   enc(6,0,0,2),        8'd6,   3, 7, 32'd0,        3, 32'd12,       0, 0};
        vecs[5]  = '{8'd6,   enc(4,3,0,3),        8'd7,   5, 3, 32'd12,       3, 32'd12,       1, 0};
        vecs[6]  = '{8'd7,   enc(6,1,0,2),        8'd8,   3, 1, 32'd12,       3, 32'd12,       0, 0};
        vecs[7]  = '{8'd8,   enc(1,4,0,8'h80),    8'd9,   4, 4, 32'hFFFFFF80, 3, 32'd12,       1, 0};
        vecs[8]  = '{8'd9,   enc(3,5,6,0),        8'd10,  4, 5, 32'd0,        3, 32'd12,       1, 0};
        vecs[9]  = '{8'd10,  enc(1,6,0,1),        8'd11,  4, 6, 32'd1,        3, 32'd12,       1, 0};
        vecs[10] = '{8'd11,  enc(3,5,6,0),        8'd12,  4, 5, 32'hFFFFFFFF, 3, 32'd12,       1, 0};
        vecs[11] = '{8'd12,  enc(4,2,3,8'hF7),    8'd13,  5, 2, 32'd12,       3, 32'd12,       1, 0};
        vecs[12] = '{8'd13,  enc(3,1,1,0),        8'd14,  4, 1, 32'd0,        3, 32'd12,       1, 0};
        vecs[13] = '{8'd14,  enc(2,4,4,0),        8'd15,  4, 4, 32'hFFFFFF00, 3, 32'd12,       1, 0};
        vecs[14] = '{8'd15,  enc(5,4,6,15),       8'd16,  4, 4, 32'hFFFFFF00, 0, 32'hFFFFFF00, 0, 1};
        vecs[15] = '{8'd16,  enc(6,1,0,100),      8'd116, 3, 1, 32'd0,        0, 32'hFFFFFF00, 0, 0};
        vecs[16] = '{8'd116, enc(6,1,0,8'hF0),    8'd100, 3, 1, 32'd0,        0, 32'hFFFFFF00, 0, 0};
        vecs[17] = '{8'd100, enc(6,1,0,127),      8'd227, 3, 1, 32'd0,        0, 32'hFFFFFF00, 0, 0};
        vecs[18] = '{8'd227, enc(6,1,0,28),       8'd255, 3, 1, 32'd0,        3, 32'd12,       0, 0};
        vecs[19] = '{8'd255, enc(6,2,0,5),        8'd0,   3, 2, 32'd12,       3, 32'd12,       0, 0};

        for (int i = 0; i < 20; i++) rom[vecs[i].at] = vecs[i].ins;
        // Skipped by the taken branch at pc 4
        rom[5] = enc(1, 7, 0, 99);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_strobes", 32'({reg_we, mem_we}), 32'd0);
        chk("rst_probe_reg", probe_register_file, 32'd0);
        chk("rst_probe_mem", probe_data_memory, 32'd0);
        rst = 1'b1;

        // run low holds in FETCH
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_pc", 32'(pc), 32'd0);
            chk("hold_strobes", 32'({reg_we, mem_we}), 32'd0);
        end

        for (int i = 0; i < 20; i++) step(vecs[i]);

        // Async reset mid-run clears everything
        run = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 8; i++) begin
            probe_reg_addr = 3'(i);
            #1;
            chk("midrst_reg", probe_register_file, 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            probe_mem_addr = 4'(i);
            #1;
            chk("midrst_mem", probe_data_memory, 32'd0);
        end

        // HALT: absorbing, pc frozen regardless of run
        rom[0] = enc(1, 1, 0, 3);
        rom[1] = enc(7, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20 && pc != 8'd1; k++) @(negedge clk);
        chk("halt_reach", 32'(pc), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("halt_early", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        chk("halt_set", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            run = 1'($urandom_range(0, 1));
            chk("halt_pc", 32'(pc), 32'd1);
            chk("halt_hold", 32'(halted), 32'd1);
            chk("halt_strobes", 32'({reg_we, mem_we}), 32'd0);
        end
        probe_reg_addr = 3'd1;
        #1;
        chk("halt_r1", probe_register_file, 32'd3);

        // Reset during LW MEM cancels the load
        rst = 1'b0;
        run = 1'b1;
        rom[0] = enc(1, 2, 0, 9);
        rom[1] = enc(5, 2, 0, 5);
        rom[2] = enc(4, 3, 0, 5);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 30 && pc != 8'd2; k++) @(negedge clk);
        chk("lwrst_reach", 32'(pc), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        probe_mem_addr = 4'd5;
        probe_reg_addr = 3'd3;
        #1;
        chk("lwrst_sw_landed", probe_data_memory, 32'd9);
        chk("lwrst_we_in_mem", 32'(reg_we), 32'd0);
        rst = 1'b0;
        #1;
        chk("lwrst_pc", 32'(pc), 32'd0);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lwrst_r3", probe_register_file, 32'd0);
        chk("lwrst_strobe", 32'(reg_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
